wb_port_arbiter: RTL and testbench
==================================

# wb_port_arbiter

- Shares the single register-file write port between three producers: ALU, load unit, multi-cycle mul/div unit.
- Grants one requester per cycle and registers the winner's rd and data into the writeback stage.
- Drives the 2-bit select of the writeback 3:1 data mux.
- Sits between execute/memory-stage producers and the register file.

## Interface

Parameters:
- XLEN, 32, data width
- NSRC, 3, number of requesters (fixed; index 0=ALU, 1=LOAD, 2=MULDIV)

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  reset, synchronous, active-low
- req_valid  in  NSRC  request pending per source
- req_rd  in  NSRC*5  destination register per source, {src2,src1,src0}
- req_data  in  NSRC*XLEN  write data per source, same packing
- req_ready  out  NSRC  one-hot grant / accept per source, combinational
- wb_en  out  1  register-file write enable
- wb_rd  out  5  register-file write address
- wb_data  out  XLEN  register-file write data
- wb_sel  out  2  winner encoding: 2'b00 ALU, 2'b01 LOAD, 2'b10 MULDIV
- flush  in  1  synchronous pipeline flush

## Operation

- Handshake:
  - Source asserts req_valid with stable req_rd/req_data and holds them until a cycle with req_ready=1.
  - Transfer occurs on a clock edge where valid&&ready.
  - req_valid must not depend on req_ready.
- Grant: req_ready is one-hot or zero. It is zero when no valid, when flush=1, or when rst_n=0.
- Arbitration: see Configuration.
- Output register:
  - On transfer, next cycle: wb_en=1 if granted rd!=0, else 0; wb_rd=granted rd; wb_data=granted data; wb_sel=granted index.
  - Cycle with no transfer: wb_en=0; wb_rd, wb_data, wb_sel hold their previous values.
- x0 handling: rd==0 requests are still accepted (source is released) but produce no write.
- Flush: req_ready=0 and the next wb_en=0. The output register still clears wb_en for the current registered entry on the next edge. Round-robin pointer is unchanged.
- Reset (rst_n low at an edge):
  - wb_en=0, wb_rd=0, wb_data=0, wb_sel=2'b00.
  - Round-robin pointer = 0 (ALU first).
  - req_ready=0 while rst_n=0.
  - A transfer in progress is discarded; the source must re-present it after reset.

## Timing

- Accept-to-write latency: 1 cycle. Request accepted at edge N gives wb_en high during cycle N+1, written by the register file at edge N+1.
- Throughput: one writeback per cycle; back-to-back grants allowed to any source.
- Single requester: ready in the same cycle valid is seen; no bubble.
- Simultaneous requests: exactly one granted; losers keep valid asserted and are served in later cycles.
- Worst-case wait per source: NSRC-1 cycles with RR enabled; unbounded for MULDIV without it.

## Configuration

- Macro: WB_PORT_ARBITER_RR_EN.
- Defined (round-robin):
  - Priority starts at pointer p and rotates p, p+1, p+2 (mod 3).
  - After each transfer, p = winner+1 mod 3.
  - Pointer updates only on transfer, never on idle or flush cycles.
- Undefined (fixed priority): ALU > LOAD > MULDIV; no pointer state exists.
- All other behaviour is identical in both builds.

## Structure

- Shared package wb_arb_pkg:
  - localparams SRC_ALU=2'b00, SRC_LOAD=2'b01, SRC_MULDIV=2'b10.
  - NSRC=3.
  - A function converting one-hot grant to 2-bit encoding.
- Sub-module wb_arb_grant: combinational grant logic.
  - Inputs: valid vector, pointer (RR build).
  - Output: one-hot grant.
- Top level holds the pointer, the output register, flush/reset gating and the data/rd muxing.

## Test plan

- Reset: rst_n=0 for 2 cycles with all sources valid -> req_ready=0, wb_en=0, wb_rd=0, wb_data=0, wb_sel=00; after release, first grant to ALU.
- Single source: LOAD valid with rd=5, data=0xDEADBEEF for one cycle -> req_ready=3'b010 that cycle; next cycle wb_en=1, wb_rd=5, wb_data=0xDEADBEEF, wb_sel=01.
- Contention, RR build: all three valid continuously for 6 cycles -> grant order ALU, LOAD, MULDIV, ALU, LOAD, MULDIV. Fixed build: ALU granted all 6 cycles, MULDIV never granted.
- x0 write: ALU valid with rd=0, data=0x1234 -> req_ready[0]=1; next cycle wb_en=0, wb_sel=00.
- Flush: ALU and MULDIV valid with flush=1 -> req_ready=0, next wb_en=0, pointer unchanged. Flush dropped -> grant resumes from the prior pointer.
- Mid-stream reset: transfer accepted at edge N, rst_n=0 at edge N+1 -> wb_en=0 after edge N+1; pointer=0.

Source files
------------

// File: rtl/wb_arb_pkg.sv
// Shared constants and helpers for the writeback port arbiter.
// Source indices double as the writeback mux select encoding.
package wb_arb_pkg;

    localparam int NSRC = 3;

    localparam logic [1:0] SRC_ALU    = 2'b00;
    localparam logic [1:0] SRC_LOAD   = 2'b01;
    localparam logic [1:0] SRC_MULDIV = 2'b10;

    function automatic logic [1:0] grant_to_sel(input logic [NSRC-1:0] grant);
        logic [1:0] sel;
        case (grant)
            3'b010:  sel = SRC_LOAD;
            3'b100:  sel = SRC_MULDIV;
            default: sel = SRC_ALU;
        endcase
        return sel;
    endfunction

    // Isolates the lowest set bit, i.e. index 0 has the highest priority.
    function automatic logic [NSRC-1:0] fixed_priority(input logic [NSRC-1:0] valid);
        return valid & (~valid + 3'd1);
    endfunction

endpackage

// File: rtl/wb_arb_grant.sv
// Combinational one-hot grant for the writeback arbiter.
// WB_PORT_ARBITER_RR_EN selects round-robin from ptr_i; otherwise fixed ALU > LOAD > MULDIV.
module wb_arb_grant
    import wb_arb_pkg::*;
(
`ifdef WB_PORT_ARBITER_RR_EN
    input  logic [1:0]      ptr_i,
`endif
    input  logic [NSRC-1:0] valid_i,
    output logic [NSRC-1:0] grant_o
);

`ifdef WB_PORT_ARBITER_RR_EN
    logic [NSRC-1:0]   valid_rot;
    logic [NSRC-1:0]   grant_rot;
    logic [2*NSRC-1:0] grant_dbl;

    // Rotate so the pointer source sits at bit 0, pick lowest, rotate back.
    always_comb begin
        valid_rot = NSRC'({valid_i, valid_i} >> ptr_i);
        grant_rot = fixed_priority(valid_rot);
        grant_dbl = {{NSRC{1'b0}}, grant_rot} << ptr_i;
        grant_o   = grant_dbl[NSRC-1:0] | grant_dbl[2*NSRC-1:NSRC];
    end
`else
    always_comb begin
        grant_o = fixed_priority(valid_i);
    end
`endif

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single register-file write port between ALU, LOAD and MULDIV.
// Build option WB_PORT_ARBITER_RR_EN enables round-robin; default is fixed priority.
module wb_port_arbiter
    import wb_arb_pkg::grant_to_sel;
    import wb_arb_pkg::SRC_ALU;
    import wb_arb_pkg::SRC_MULDIV;
#(
    parameter int XLEN = 32,
    parameter int NSRC = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NSRC-1:0]      req_valid,
    input  logic [NSRC*5-1:0]    req_rd,
    input  logic [NSRC*XLEN-1:0] req_data,
    output logic [NSRC-1:0]      req_ready,
    output logic                 wb_en,
    output logic [4:0]           wb_rd,
    output logic [XLEN-1:0]      wb_data,
    output logic [1:0]           wb_sel,
    input  logic                 flush
);

    logic [NSRC-1:0] grant;
    logic            xfer;
    logic [1:0]      sel_idx;
    logic [4:0]      sel_rd;
    logic [XLEN-1:0] sel_data;

    logic            wb_en_q,   wb_en_d;
    logic [4:0]      wb_rd_q,   wb_rd_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [1:0]      wb_sel_q,  wb_sel_d;

`ifdef WB_PORT_ARBITER_RR_EN
    logic [1:0]      ptr_q, ptr_d;

    wb_arb_grant u_grant (
        .ptr_i   (ptr_q),
        .valid_i (req_valid),
        .grant_o (grant)
    );
`else
    wb_arb_grant u_grant (
        .valid_i (req_valid),
        .grant_o (grant)
    );
`endif

    // Reset and flush suppress the grant so no source is released.
    always_comb begin
        req_ready = (rst_n && !flush) ? grant : '0;
        xfer      = |req_ready;
        sel_idx   = grant_to_sel(req_ready);
        sel_rd    = '0;
        sel_data  = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (req_ready[i]) begin
                sel_rd   = sel_rd | req_rd[i*5 +: 5];
                sel_data = sel_data | req_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 destinations are accepted but never enable the write.
    always_comb begin
        wb_en_d   = xfer && (sel_rd != 5'd0);
        wb_rd_d   = xfer ? sel_rd   : wb_rd_q;
        wb_data_d = xfer ? sel_data : wb_data_q;
        wb_sel_d  = xfer ? sel_idx  : wb_sel_q;
`ifdef WB_PORT_ARBITER_RR_EN
        ptr_d = ptr_q;
        if (xfer) begin
            ptr_d = (sel_idx == SRC_MULDIV) ? SRC_ALU : sel_idx + 2'd1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_rd_q   <= '0;
            wb_data_q <= '0;
            wb_sel_q  <= SRC_ALU;
`ifdef WB_PORT_ARBITER_RR_EN
            ptr_q     <= SRC_ALU;
`endif
        end else begin
            wb_en_q   <= wb_en_d;
            wb_rd_q   <= wb_rd_d;
            wb_data_q <= wb_data_d;
            wb_sel_q  <= wb_sel_d;
`ifdef WB_PORT_ARBITER_RR_EN
            ptr_q     <= ptr_d;
`endif
        end
    end

    assign wb_en   = wb_en_q;
    assign wb_rd   = wb_rd_q;
    assign wb_data = wb_data_q;
    assign wb_sel  = wb_sel_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: a behavioural arbiter model predicts grants
// and pushes the expected writeback into a scoreboard queue checked one cycle later.
module tb_wb_port_arbiter;

    localparam int XLEN = 32;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [1:0]  sel;
    } wb_entry_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic [2:0]  req_valid;
    logic [14:0] req_rd;
    logic [95:0] req_data;
    logic [2:0]  req_ready;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  wb_sel;

    wb_entry_t sb_q[$];
    wb_entry_t model_out;
    int        model_ptr  = 0;
    int        num_checks = 0;
    int        num_fail   = 0;

    always #5 clk = ~clk;

    wb_port_arbiter #(.XLEN(XLEN), .NSRC(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_rd    (req_rd),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wb_en     (wb_en),
        .wb_rd     (wb_rd),
        .wb_data   (wb_data),
        .wb_sel    (wb_sel),
        .flush     (flush)
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Walks priority order starting at the pointer; fixed build always starts at ALU.
    function automatic logic [2:0] model_grant(input logic [2:0] v, input int p, input logic rst_v, input logic fl);
        logic [2:0] g;
        int         start;
        g = 3'b000;
        if (!rst_v || fl) return g;
`ifdef WB_PORT_ARBITER_RR_EN
        start = p;
`else
        start = 0 * p;
`endif
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (start + k) % 3;
            if (v[i]) begin
                g[i] = 1'b1;
                return g;
            end
        end
        return g;
    endfunction

    task automatic applyStimulus(input logic rst_v, input logic fl, input logic [2:0] v,
                                 input logic [14:0] rd, input logic [95:0] data);
        logic [2:0] g;
        wb_entry_t  e;
        rst_n     = rst_v;
        flush     = fl;
        req_valid = v;
        req_rd    = rd;
        req_data  = data;
        @(negedge clk);
        g = model_grant(v, model_ptr, rst_v, fl);
        checkOutput("req_ready", {61'd0, req_ready}, {61'd0, g});
        for (int i = 0; i < 3; i++) begin
            if (g[i]) begin
                e.rd   = rd[i*5 +: 5];
                e.data = data[i*32 +: 32];
                e.sel  = 2'(i);
                e.en   = (e.rd != 5'd0);
                sb_q.push_back(e);
                model_ptr = (i + 1) % 3;
            end
        end
        if (!rst_v) model_ptr = 0;
        @(posedge clk);
        #1;
        if (!rst_v) begin
            sb_q.delete();
            model_out = '0;
        end else if (sb_q.size() > 0) begin
            model_out = sb_q.pop_front();
        end else begin
            model_out.en = 1'b0;
        end
        checkOutput("wb_en",   {63'd0, wb_en},   {63'd0, model_out.en});
        checkOutput("wb_rd",   {59'd0, wb_rd},   {59'd0, model_out.rd});
        checkOutput("wb_data", {32'd0, wb_data}, {32'd0, model_out.data});
        checkOutput("wb_sel",  {62'd0, wb_sel},  {62'd0, model_out.sel});
    endtask

    initial begin
        logic [14:0] rds;
        logic [95:0] dats;
        rds  = {5'd3, 5'd2, 5'd1};
        dats = {32'hCCCC_0003, 32'hBBBB_0002, 32'hAAAA_0001};
        model_out = '0;

        $display("[TB] reset with all sources valid");
        applyStimulus(1'b0, 1'b0, 3'b111, rds, dats);
        applyStimulus(1'b0, 1'b0, 3'b111, rds, dats);
        applyStimulus(1'b1, 1'b0, 3'b111, rds, dats);
        applyStimulus(1'b1, 1'b0, 3'b000, rds, dats);

        $display("[TB] single LOAD request");
        applyStimulus(1'b1, 1'b0, 3'b010, {5'd0, 5'd5, 5'd0}, {32'd0, 32'hDEAD_BEEF, 32'd0});
        applyStimulus(1'b1, 1'b0, 3'b000, rds, dats);

        $display("[TB] three-way contention");
        for (int c = 0; c < 6; c++) begin
            applyStimulus(1'b1, 1'b0, 3'b111, {5'd30, 5'd20, 5'(10 + c)},
                          {32'h3000_0000 + c, 32'h2000_0000 + c, 32'h1000_0000 + c});
        end
        applyStimulus(1'b1, 1'b0, 3'b000, rds, dats);

        $display("[TB] x0 destination");
        applyStimulus(1'b1, 1'b0, 3'b001, {5'd7, 5'd6, 5'd0}, {32'd0, 32'd0, 32'h0000_1234});
        applyStimulus(1'b1, 1'b0, 3'b000, rds, dats);

        $display("[TB] flush then resume");
        applyStimulus(1'b1, 1'b0, 3'b010, rds, dats);
        applyStimulus(1'b1, 1'b1, 3'b101, rds, dats);
        applyStimulus(1'b1, 1'b1, 3'b101, rds, dats);
        applyStimulus(1'b1, 1'b0, 3'b101, rds, dats);
        applyStimulus(1'b1, 1'b0, 3'b101, rds, dats);

        $display("[TB] random traffic");
        for (int c = 0; c < 40; c++) begin
            applyStimulus(1'b1, ($urandom_range(0, 5) == 0), 3'($urandom_range(0, 7)),
                          15'($urandom), {$urandom, $urandom, $urandom});
        end

        $display("[TB] mid-stream reset");
        applyStimulus(1'b1, 1'b0, 3'b010, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h5555_AAAA, 32'd0});
        applyStimulus(1'b0, 1'b0, 3'b111, rds, dats);
        applyStimulus(1'b1, 1'b0, 3'b111, rds, dats);
        applyStimulus(1'b1, 1'b0, 3'b110, rds, dats);
        applyStimulus(1'b1, 1'b0, 3'b000, rds, dats);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

endmodule
